// File: rtl/victim_way_selector.sv
// victim_way_selector: per-set victim way choice with a single-entry registered response.
// Define VICTIM_PLRU_EN for tree-PLRU replacement; otherwise a per-set round-robin counter is used.
module victim_way_selector #(
    parameter int WAYS_P = 4,
    parameter int SETS_P = 16
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      req_v_i,
    output logic                      req_ready_o,
    input  logic [$clog2(SETS_P)-1:0] req_set_i,
    input  logic [WAYS_P-1:0]         valid_i,
    output logic                      resp_v_o,
    input  logic                      resp_ready_i,
    output logic [$clog2(WAYS_P)-1:0] resp_way_o,
    output logic                      resp_fill_o,
    input  logic                      touch_v_i,
    input  logic [$clog2(SETS_P)-1:0] touch_set_i,
    input  logic [$clog2(WAYS_P)-1:0] touch_way_i
);
    localparam int WW = $clog2(WAYS_P);

    logic          acc;
    logic          full;
    logic [WW-1:0] fill_way;
    logic [WW-1:0] victim;

    assign req_ready_o = !resp_v_o || resp_ready_i;
    assign acc         = req_v_i && req_ready_o;
    assign full        = &valid_i;

    // lowest-index invalid way, scanning downward so the lowest hit wins
    always_comb begin
        fill_way = '0;
        for (int i = WAYS_P - 1; i >= 0; i--)
            if (!valid_i[i]) fill_way = WW'(i);
    end

`ifdef VICTIM_PLRU_EN
    logic [WAYS_P-2:0] plru_q [SETS_P];

    function automatic logic [WAYS_P-2:0] plru_touch(input logic [WAYS_P-2:0] s, input logic [WW-1:0] w);
        logic [WAYS_P-2:0] r;
        int n;
        r = s;
        n = 0;
        for (int l = 0; l < WW; l++) begin
            r[n] = ~w[WW-1-l];
            n    = 2 * n + 1 + 32'(w[WW-1-l]);
        end
        return r;
    endfunction

    function automatic logic [WW-1:0] plru_victim(input logic [WAYS_P-2:0] s);
        logic [WW-1:0] w;
        int n;
        w = '0;
        n = 0;
        for (int l = 0; l < WW; l++) begin
            w[WW-1-l] = s[n];
            n         = 2 * n + 1 + 32'(w[WW-1-l]);
        end
        return w;
    endfunction

    assign victim = plru_victim(plru_q[req_set_i]);

    // victim issue counts as a touch of the victim and overrides a same-set touch
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < SETS_P; s++) plru_q[s] <= '0;
        end else begin
            if (acc && full)
                plru_q[req_set_i] <= plru_touch(plru_q[req_set_i], victim);
            if (touch_v_i && !(acc && full && touch_set_i == req_set_i))
                plru_q[touch_set_i] <= plru_touch(plru_q[touch_set_i], touch_way_i);
        end
    end
`else
    logic [WW-1:0] rr_q [SETS_P];
    logic          unused_touch;

    assign unused_touch = ^{touch_v_i, touch_set_i, touch_way_i};
    assign victim       = rr_q[req_set_i];

    // round-robin pointer advances only when a full-set victim is issued
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int s = 0; s < SETS_P; s++) rr_q[s] <= '0;
        end else if (acc && full) begin
            rr_q[req_set_i] <= rr_q[req_set_i] + WW'(1);
        end
    end
`endif

    // single-entry response register; reload on accept, clear on consume
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            resp_v_o    <= 1'b0;
            resp_way_o  <= '0;
            resp_fill_o <= 1'b0;
        end else if (acc) begin
            resp_v_o    <= 1'b1;
            resp_way_o  <= full ? victim : fill_way;
            resp_fill_o <= !full;
        end else if (resp_ready_i) begin
            resp_v_o    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_victim_way_selector.sv
// tb_victim_way_selector: directed checks of victim_way_selector (WAYS_P=4, SETS_P=16); honours VICTIM_PLRU_EN.
module tb_victim_way_selector;
    logic       clk_i = 1'b0;
    logic       reset_n_i;
    logic       req_v_i;
    logic       req_ready_o;
    logic [3:0] req_set_i;
    logic [3:0] valid_i;
    logic       resp_v_o;
    logic       resp_ready_i;
    logic [1:0] resp_way_o;
    logic       resp_fill_o;
    logic       touch_v_i;
    logic [3:0] touch_set_i;
    logic [1:0] touch_way_i;

    int checks = 0;
    int errors = 0;

`ifdef VICTIM_PLRU_EN
    localparam bit PLRU = 1'b1;
`else
    localparam bit PLRU = 1'b0;
`endif

    victim_way_selector #(.WAYS_P(4), .SETS_P(16)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .req_v_i(req_v_i), .req_ready_o(req_ready_o),
        .req_set_i(req_set_i), .valid_i(valid_i), .resp_v_o(resp_v_o), .resp_ready_i(resp_ready_i),
        .resp_way_o(resp_way_o), .resp_fill_o(resp_fill_o), .touch_v_i(touch_v_i),
        .touch_set_i(touch_set_i), .touch_way_i(touch_way_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        reset_n_i = 1'b0; req_v_i = 1'b0; req_set_i = '0; valid_i = '0; resp_ready_i = 1'b1;
        touch_v_i = 1'b0; touch_set_i = '0; touch_way_i = '0;
        step(); step();
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL reset_resp_v got %b exp 0", resp_v_o); end
        checks++; if (resp_way_o !== 2'd0) begin errors++; $display("FAIL reset_resp_way got %0d exp 0", resp_way_o); end
        checks++; if (resp_fill_o !== 1'b0) begin errors++; $display("FAIL reset_resp_fill got %b exp 0", resp_fill_o); end
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready_o); end
        #2 reset_n_i = 1'b1;
        step();
    endtask

    task automatic test_fill();
        req_v_i = 1'b1; req_set_i = 4'd3; valid_i = 4'b1011;
        step();
        req_v_i = 1'b0;
        checks++; if (resp_v_o !== 1'b1) begin errors++; $display("FAIL fill_resp_v got %b exp 1", resp_v_o); end
        checks++; if (resp_way_o !== 2'd2) begin errors++; $display("FAIL fill_way got %0d exp 2", resp_way_o); end
        checks++; if (resp_fill_o !== 1'b1) begin errors++; $display("FAIL fill_flag got %b exp 1", resp_fill_o); end
        step();
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL fill_consumed got %b exp 0", resp_v_o); end
        req_v_i = 1'b1; req_set_i = 4'd3; valid_i = 4'b1111;
        step();
        req_v_i = 1'b0;
        checks++; if (resp_way_o !== 2'd0) begin errors++; $display("FAIL fill_no_update got %0d exp 0", resp_way_o); end
        checks++; if (resp_fill_o !== 1'b0) begin errors++; $display("FAIL full_flag got %b exp 0", resp_fill_o); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_way [4];
        exp_way = PLRU ? '{2'd0, 2'd2, 2'd1, 2'd3} : '{2'd0, 2'd1, 2'd2, 2'd3};
        req_v_i = 1'b1; req_set_i = 4'd7; valid_i = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i == 3) req_v_i = 1'b0;
            checks++; if (resp_v_o !== 1'b1) begin errors++; $display("FAIL b2b_v[%0d] got %b exp 1", i, resp_v_o); end
            checks++; if (resp_way_o !== exp_way[i]) begin errors++; $display("FAIL b2b_way[%0d] got %0d exp %0d", i, resp_way_o, exp_way[i]); end
            checks++; if (resp_fill_o !== 1'b0) begin errors++; $display("FAIL b2b_fill[%0d] got %b exp 0", i, resp_fill_o); end
        end
        step();
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b exp 0", resp_v_o); end
    endtask

    task automatic test_stall();
        resp_ready_i = 1'b0; req_v_i = 1'b1; req_set_i = 4'd1; valid_i = 4'b0111;
        step();
        req_set_i = 4'd2; valid_i = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            checks++; if (req_ready_o !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d] got %b exp 0", i, req_ready_o); end
            checks++; if (resp_v_o !== 1'b1 || resp_way_o !== 2'd3 || resp_fill_o !== 1'b1) begin
                errors++; $display("FAIL stall_hold[%0d] got v%b w%0d f%b exp v1 w3 f1", i, resp_v_o, resp_way_o, resp_fill_o);
            end
            step();
        end
        resp_ready_i = 1'b1;
        #1;
        checks++; if (req_ready_o !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b exp 1", req_ready_o); end
        step();
        req_v_i = 1'b0;
        checks++; if (resp_v_o !== 1'b1 || resp_way_o !== 2'd1 || resp_fill_o !== 1'b1) begin
            errors++; $display("FAIL stall_next got v%b w%0d f%b exp v1 w1 f1", resp_v_o, resp_way_o, resp_fill_o);
        end
        step();
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL stall_drain got %b exp 0", resp_v_o); end
    endtask

    task automatic test_touch();
        touch_v_i = 1'b1; touch_set_i = 4'd5; touch_way_i = 2'd0;
        step();
        touch_v_i = 1'b0; req_v_i = 1'b1; req_set_i = 4'd5; valid_i = 4'b1111;
        step();
        req_v_i = 1'b0;
        checks++; if (resp_way_o !== (PLRU ? 2'd2 : 2'd0)) begin
            errors++; $display("FAIL touch_way got %0d exp %0d", resp_way_o, PLRU ? 2'd2 : 2'd0);
        end
        step();
    endtask

    task automatic test_collide();
        touch_v_i = 1'b1; touch_set_i = 4'd9; touch_way_i = 2'd2;
        req_v_i = 1'b1; req_set_i = 4'd9; valid_i = 4'b1111;
        step();
        touch_v_i = 1'b0;
        checks++; if (resp_way_o !== 2'd0) begin errors++; $display("FAIL collide_first got %0d exp 0", resp_way_o); end
        step();
        req_v_i = 1'b0;
        checks++; if (resp_way_o !== (PLRU ? 2'd2 : 2'd1)) begin
            errors++; $display("FAIL collide_second got %0d exp %0d", resp_way_o, PLRU ? 2'd2 : 2'd1);
        end
        step();
    endtask

    task automatic test_async_reset();
        resp_ready_i = 1'b0; req_v_i = 1'b1; req_set_i = 4'd7; valid_i = 4'b1111;
        step();
        req_v_i = 1'b0;
        checks++; if (resp_v_o !== 1'b1) begin errors++; $display("FAIL areset_pending got %b exp 1", resp_v_o); end
        #2 reset_n_i = 1'b0;
        #1;
        checks++; if (resp_v_o !== 1'b0) begin errors++; $display("FAIL areset_drop got %b exp 0", resp_v_o); end
        #3 reset_n_i = 1'b1;
        resp_ready_i = 1'b1;
        step();
        req_v_i = 1'b1; req_set_i = 4'd7; valid_i = 4'b1111;
        step();
        req_v_i = 1'b0;
        checks++; if (resp_v_o !== 1'b1 || resp_way_o !== 2'd0) begin
            errors++; $display("FAIL areset_state got v%b w%0d exp v1 w0", resp_v_o, resp_way_o);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_fill();
        test_back_to_back();
        test_stall();
        test_touch();
        test_collide();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/victim_way_selector.md
VICTIM_WAY_SELECTOR -- requirements
Module: victim_way_selector

Interface
REQ-001 SHALL have parameter WAYS_P, default 4, associativity; power of 2, range 2..16.
REQ-002 SHALL have parameter SETS_P, default 16, number of sets tracked; power of 2, at least 2.
REQ-003 SHALL have one clock and asynchronous active-low reset: clk_i  in  1  rising-edge clock.
REQ-004 SHALL have reset_n_i  in  1  asynchronous active-low reset.
REQ-005 SHALL have req_v_i  in  1  victim request valid.
REQ-006 SHALL have req_ready_o  out  1  request accepted when req_v_i && req_ready_o.
REQ-007 SHALL have req_set_i  in  log2(SETS_P)  set index of the request.
REQ-008 SHALL have valid_i  in  WAYS_P  per-way valid bits of the requested set; bit n = way n.
REQ-009 SHALL have resp_v_o  out  1  response valid.
REQ-010 SHALL have resp_ready_i  in  1  response consumed when resp_v_o && resp_ready_i.
REQ-011 SHALL have resp_way_o  out  log2(WAYS_P)  selected way.
REQ-012 SHALL have resp_fill_o  out  1  1 = an invalid way was chosen; 0 = replacement.
REQ-013 SHALL have touch_v_i  in  1  hit/access update strobe.
REQ-014 SHALL have touch_set_i  in  log2(SETS_P)  set index of the touch.
REQ-015 SHALL have touch_way_i  in  log2(WAYS_P)  accessed way.

Function
REQ-016 SHALL hold a single-entry registered response; req_ready_o = !resp_v_o || resp_ready_i (combinational).
REQ-017 SHALL present the response one cycle after acceptance; resp_v_o, resp_way_o and resp_fill_o SHALL be held stable while resp_v_o && !resp_ready_i.
REQ-018 SHALL, on acceptance with any valid_i bit 0, return the lowest-index way whose bit is 0, with resp_fill_o=1, and SHALL leave the replacement state unchanged.
REQ-019 SHALL, on acceptance with valid_i all ones, return the replacement victim of req_set_i, with resp_fill_o=0, and SHALL update that set's state as though the victim way were touched.
REQ-020 SHALL compute the victim from the state present before the clock edge of acceptance.
REQ-021 SHALL, on touch_v_i=1, update the state of touch_set_i for touch_way_i at the clock edge; touches SHALL be independent of the handshake and SHALL never stall.
REQ-022 SHALL, when a touch and a full-set acceptance target the same set in the same cycle, apply the victim update only and discard the touch.
REQ-023 SHALL, when the response is consumed and a new request is accepted in the same cycle, load the new response with no bubble.

Reset
REQ-024 SHALL, while reset_n_i=0, drive resp_v_o=0, resp_way_o=0 and resp_fill_o=0, and clear all per-set replacement state to 0.
REQ-025 SHALL, on reset asserted mid-operation, drop any pending response immediately (asynchronously).

Configuration
REQ-026 SHALL, with VICTIM_PLRU_EN defined, keep WAYS_P-1 tree-PLRU bits per set: root node 0, children of node n are 2n+1 (lower ways) and 2n+2 (upper ways).
REQ-027 SHALL, in PLRU mode, select the victim by walking from the root: bit 0 selects the lower half, bit 1 the upper half.
REQ-028 SHALL, in PLRU mode, set every node on a touched way's path to point away from that way.
REQ-029 SHALL, with VICTIM_PLRU_EN undefined, keep a log2(WAYS_P)-bit round-robin counter per set: victim = counter, incremented modulo WAYS_P on each full-set victim issue; touch inputs SHALL be ignored.

Verification (WAYS_P=4, SETS_P=16)
REQ-030 SHALL cover: after reset, request set 3 with valid_i=4'b1011 -> next cycle resp_v_o=1, resp_way_o=2, resp_fill_o=1.
REQ-031 SHALL cover: four back-to-back requests to set 7 with valid_i=4'b1111 and resp_ready_i=1 -> PLRU victims 0,2,1,3; round-robin victims 0,1,2,3; resp_fill_o=0 each time.
REQ-032 SHALL cover: resp_ready_i=0 for 5 cycles with response pending -> req_ready_o=0 and outputs stable; a new request is accepted in the cycle resp_ready_i rises.
REQ-033 SHALL cover: PLRU, touch set 5 way 0, then request set 5 full -> resp_way_o=2.
REQ-034 SHALL cover: PLRU fresh set 9, same cycle touch way 2 and full request -> victim 0; next full request -> victim 2 (touch discarded).
REQ-035 SHALL cover: reset_n_i pulsed low while resp_v_o=1 -> resp_v_o=0 at once; a following full request to any previously used set -> victim 0.
